lfsr16_checker: RTL

//   Receive-side pattern checker for the 16-bit LFSR generator. It uses polynomial x^16+x^14+x^13+x^11+1,

---
 rtl/lfsr16_checker.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lfsr16_checker.sv
// Receive-side checker for the x^16+x^14+x^13+x^11+1 LFSR stream: hunts for lock, then free-runs and counts errors.
// Optional bit-error counting is enabled by defining LFSR16_CHK_BITERR_EN.
`timescale 1ns/1ps
module lfsr16_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid_in,
  input  logic [15:0]      data_in,
  output logic             locked,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] word_err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);

  typedef enum logic {S_HUNT, S_LOCKED} state_t;

  state_t           r_state;
  logic [15:0]      r_exp;
  logic [3:0]       r_mrun;
  logic [3:0]       r_xrun;
  logic             r_locked;
  logic             r_err;
  logic             r_sticky;
  logic [CNT_W-1:0] r_wcnt;

  logic [15:0] w_step_d;
  logic [15:0] w_step_e;
  logic        w_mismatch;
  logic        w_count_err;

  function automatic logic [15:0] f_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  assign w_step_d    = f_step(data_in);
  assign w_step_e    = f_step(r_exp);
  assign w_mismatch  = (data_in != r_exp);
  assign w_count_err = valid_in && (r_state == S_LOCKED) && w_mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_HUNT;
      r_exp    <= '0;
      r_mrun   <= '0;
      r_xrun   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
      r_wcnt   <= '0;
    end else begin
      r_err <= 1'b0;
      if (valid_in) begin
        case (r_state)
          S_HUNT: begin
            // The all-zero word is the LFSR lock-up pattern and never seeds the predictor.
            if (data_in != 16'h0000) begin
              r_exp <= w_step_d;
              if (!w_mismatch) begin
                if (r_mrun == 4'(LOCK_CNT - 1)) begin
                  r_state  <= S_LOCKED;
                  r_locked <= 1'b1;
                  r_mrun   <= '0;
                  r_xrun   <= '0;
                end else begin
                  r_mrun <= r_mrun + 4'd1;
                end
              end else begin
                r_mrun <= '0;
              end
            end
          end
          S_LOCKED: begin
            r_exp <= w_step_e;
            if (w_mismatch) begin
              r_err <= 1'b1;
              if (r_xrun == 4'(LOSS_CNT - 1)) begin
                r_state  <= S_HUNT;
                r_locked <= 1'b0;
                r_mrun   <= '0;
                r_xrun   <= '0;
                r_exp    <= w_step_d;
              end else begin
                r_xrun <= r_xrun + 4'd1;
              end
            end else begin
              r_xrun <= '0;
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end

      if (clear) begin
        r_sticky <= 1'b0;
        r_wcnt   <= '0;
      end else if (w_count_err) begin
        r_sticky <= 1'b1;
        if (!(&r_wcnt)) r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

`ifdef LFSR16_CHK_BITERR_EN
  localparam int unsigned SW = ((CNT_W > 5) ? CNT_W : 5) + 1;

  logic [CNT_W-1:0] r_bcnt;
  logic [15:0]      w_diff;
  logic [4:0]       w_pop;
  logic [SW-1:0]    w_bsum;
  logic [CNT_W-1:0] w_bnext;

  assign w_diff = data_in ^ r_exp;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < 16; i++) w_pop = w_pop + 5'(w_diff[i]);
  end

  // Sum is computed one bit wider than either operand so the clamp sees any overflow.
  assign w_bsum  = SW'(r_bcnt) + SW'(w_pop);
  assign w_bnext = (w_bsum > SW'({CNT_W{1'b1}})) ? '1 : w_bsum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n)           r_bcnt <= '0;
    else if (clear)       r_bcnt <= '0;
    else if (w_count_err) r_bcnt <= w_bnext;
  end

  assign bit_err_cnt = r_bcnt;
`else
  assign bit_err_cnt = '0;
`endif

  assign locked       = r_locked;
  assign err          = r_err;
  assign err_sticky   = r_sticky;
  assign word_err_cnt = r_wcnt;

endmodule
